// File: rtl/shift_rows_stream.sv
// shift_rows_stream: LANES x 128-bit AES ShiftRows/InvShiftRows into an output FIFO (optional counters: SHIFT_ROWS_STREAM_PERF_EN).
// Latency: beat visible the cycle after it is accepted; sustains 1 beat/cycle while out_ready is high.
// Backpressure: in_ready drops when the FIFO is full or flushing; a same-cycle pop does not reopen a full FIFO.

// sync_fifo: generic power-of-two FIFO with occupancy count and synchronous flush.
// Latency: written entry visible at rdata the cycle after push; rdata reads zero when empty.
// Backpressure: caller must not push when full nor pop when empty.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  // Zero when empty so the head output has a defined reset/flush value without resetting the array.
  assign rdata = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= wdata;
  end
endmodule

module shift_rows_stream #(
  parameter int LANES = 1,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_inv,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic [128*LANES-1:0]     in_state,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TAG_W-1:0]         out_tag,
  output logic [128*LANES-1:0]     out_state,
  output logic [$clog2(DEPTH):0]   level
`ifdef SHIFT_ROWS_STREAM_PERF_EN
  ,
  output logic [31:0]              perf_beats,
  output logic [31:0]              perf_stall
`endif
);
  typedef struct packed {
    logic [TAG_W-1:0]     tag;
    logic [128*LANES-1:0] state;
  } beat_t;

  beat_t wr_beat, rd_beat;
  logic  push, pop, full, empty;

  // Row r sits at lane bits [127-32r -: 32]; rotations are in whole bytes.
  function automatic logic [127:0] shift_lane(input logic [127:0] s, input logic inv);
    logic [31:0] r0, r1, r2, r3;
    r0 = s[127:96];
    r1 = s[95:64];
    r2 = s[63:32];
    r3 = s[31:0];
    r2 = {r2[15:0], r2[31:16]};
    if (inv) begin
      r1 = {r1[7:0],  r1[31:8]};
      r3 = {r3[23:0], r3[31:24]};
    end else begin
      r1 = {r1[23:0], r1[31:24]};
      r3 = {r3[7:0],  r3[31:8]};
    end
    return {r0, r1, r2, r3};
  endfunction

  always_comb begin
    wr_beat     = '0;
    wr_beat.tag = in_tag;
    for (int i = 0; i < LANES; i++)
      wr_beat.state[128*i +: 128] = shift_lane(in_state[128*i +: 128], in_inv);
  end

  assign in_ready  = !full && !flush;
  assign push      = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign out_tag   = rd_beat.tag;
  assign out_state = rd_beat.state;

  sync_fifo #(
    .W     ($bits(beat_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wr_beat),
    .rdata (rd_beat),
    .level (level),
    .full  (full),
    .empty (empty)
  );

`ifdef SHIFT_ROWS_STREAM_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_beats <= '0;
      perf_stall <= '0;
    end else if (flush) begin
      perf_beats <= '0;
      perf_stall <= '0;
    end else begin
      if (pop && (perf_beats != 32'hFFFF_FFFF))
        perf_beats <= perf_beats + 32'd1;
      if (out_valid && !out_ready && (perf_stall != 32'hFFFF_FFFF))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_shift_rows_stream.sv
// Bench for shift_rows_stream (LANES=2, DEPTH=2): constant vector table, directed FIFO corner sequences,
// and a randomized stream scored against a byte-level reference model.
module tb_shift_rows_stream;
  localparam int LANES = 2;
  localparam int DEPTH = 2;
  localparam int TAG_W = 4;
  localparam int SW    = 128*LANES;

  logic             clk, rst_n, flush, in_valid, in_ready, in_inv;
  logic             out_valid, out_ready;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [SW-1:0]    in_state, out_state;
  logic [1:0]       level;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [SW-1:0]    st;
  } ent_t;
  ent_t q[$];

  typedef struct {
    logic             inv;
    logic [TAG_W-1:0] tag;
    logic [SW-1:0]    st;
    logic [SW-1:0]    exp;
  } vec_t;
  vec_t vecs[5];

  shift_rows_stream #(.LANES(LANES), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inv    (in_inv),
    .in_tag    (in_tag),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tag   (out_tag),
    .out_state (out_state),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: bytes numbered 0..15 from the MS end, byte 4r+c = column c of row r.
  function automatic logic [127:0] ref_lane(input logic [127:0] s, input logic inv);
    logic [7:0]   b [16];
    logic [127:0] res;
    int           src;
    for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        res[127-8*(4*r+c) -: 8] = b[4*r+src];
      end
    return res;
  endfunction

  function automatic logic [SW-1:0] ref_beat(input logic [SW-1:0] s, input logic inv);
    logic [SW-1:0] res;
    res = '0;
    for (int l = 0; l < LANES; l++) res[128*l +: 128] = ref_lane(s[128*l +: 128], inv);
    return res;
  endfunction

  function automatic logic [SW-1:0] rand_state();
    logic [SW-1:0] s;
    for (int w = 0; w < SW/32; w++) s[32*w +: 32] = $urandom;
    return s;
  endfunction

  // One clock cycle: drive inputs, compare outputs against the model, advance the model.
  task automatic cyc(input logic v, input logic inv, input logic [TAG_W-1:0] tag,
                     input logic [SW-1:0] st, input logic ordy, input logic fl);
    logic acc;
    in_valid = v; in_inv = inv; in_tag = tag; in_state = st; out_ready = ordy; flush = fl;
    #1;
    acc = (q.size() < DEPTH) && !fl;
    chk("in_ready", SW'(in_ready), SW'(acc));
    chk("out_valid", SW'(out_valid), SW'(q.size() != 0));
    chk("level", SW'(level), SW'(q.size()));
    if (q.size() != 0) begin
      chk("out_tag", SW'(out_tag), SW'(q[0].tag));
      chk("out_state", out_state, q[0].st);
    end
    if (fl) q.delete();
    else begin
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (v && acc) q.push_back('{tag, ref_beat(st, inv)});
    end
    @(negedge clk);
  endtask

  initial begin
    int acc_cnt;
    int budget;
    logic [SW-1:0] s;

    vecs[0] = '{1'b0, 4'h1, {128'h0, 128'h00010203_10111213_20212223_30313233},
                {128'h0, 128'h00010203_11121310_22232021_33303132}};
    vecs[1] = '{1'b1, 4'h2, {128'h0, 128'h00010203_10111213_20212223_30313233},
                {128'h0, 128'h00010203_13101112_22232021_31323330}};
    vecs[2] = '{1'b1, 4'h3, {128'h0, 128'h00010203_11121310_22232021_33303132},
                {128'h0, 128'h00010203_10111213_20212223_30313233}};
    vecs[3] = '{1'b0, 4'h4,
                {128'h40414243_50515253_60616263_70717273, 128'h80818283_90919293_a0a1a2a3_b0b1b2b3},
                {128'h40414243_51525350_62636061_73707172, 128'h80818283_91929390_a2a3a0a1_b3b0b1b2}};
    vecs[4] = '{1'b1, 4'hf,
                {128'h40414243_50515253_60616263_70717273, 128'h80818283_90919293_a0a1a2a3_b0b1b2b3},
                {128'h40414243_53505152_62636061_71727370, 128'h80818283_93909192_a2a3a0a1_b1b2b3b0}};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_tag = '0; in_state = '0; out_ready = 1'b0;
    #1;
    chk("rst_level", SW'(level), '0);
    chk("rst_out_valid", SW'(out_valid), '0);
    chk("rst_out_state", out_state, '0);
    chk("rst_out_tag", SW'(out_tag), '0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", SW'(in_ready), SW'(1'b1));
    @(negedge clk);

    // Vector table: one beat in, check next cycle, drain.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, vecs[i].inv, vecs[i].tag, vecs[i].st, 1'b1, 1'b0);
      chk("vec_state", out_state, vecs[i].exp);
      chk("vec_tag", SW'(out_tag), SW'(vecs[i].tag));
      chk("vec_level", SW'(level), SW'(1));
      cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    end

    // Fill to DEPTH with out_ready low, then release.
    cyc(1'b1, 1'b0, 4'd1, rand_state(), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 4'd2, rand_state(), 1'b0, 1'b0);
    s = rand_state();
    cyc(1'b1, 1'b0, 4'd3, s, 1'b0, 1'b0);
    chk("full_level", SW'(level), SW'(2));
    chk("full_in_ready", SW'(in_ready), '0);
    chk("full_head_tag", SW'(out_tag), SW'(1));
    cyc(1'b1, 1'b0, 4'd3, s, 1'b1, 1'b0);
    chk("drain_tag2", SW'(out_tag), SW'(2));
    chk("drain_level1", SW'(level), SW'(1));
    cyc(1'b1, 1'b0, 4'd3, s, 1'b1, 1'b0);
    chk("drain_tag3", SW'(out_tag), SW'(3));
    chk("drain_state3", out_state, ref_beat(s, 1'b0));
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    chk("drain_empty", SW'(level), '0);

    // Flush with a concurrent push attempt.
    cyc(1'b1, 1'b0, 4'd5, rand_state(), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 4'd6, rand_state(), 1'b1, 1'b1);
    chk("flush_level", SW'(level), '0);
    chk("flush_out_valid", SW'(out_valid), '0);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    // Randomized full-rate stream with random back-pressure.
    acc_cnt = 0;
    budget  = 0;
    while (acc_cnt < 20 && budget < 300) begin
      if (q.size() < DEPTH) acc_cnt++;
      cyc(1'b1, 1'($urandom_range(1)), 4'($urandom), rand_state(), 1'($urandom_range(1)), 1'b0);
      budget++;
    end
    chk("stream_accepted", SW'(acc_cnt), SW'(20));
    cyc(1'b1, 1'($urandom_range(1)), 4'($urandom), rand_state(), 1'b0, 1'b0);
    cyc(1'b1, 1'($urandom_range(1)), 4'($urandom), rand_state(), 1'b0, 1'b0);
    chk("pre_reset_level", SW'(level), SW'(2));

    // Asynchronous reset mid-stream.
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", SW'(out_valid), '0);
    chk("async_level", SW'(level), '0);
    chk("async_out_state", out_state, '0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 4'd9, rand_state(), 1'b1, 1'b0);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
